row_stream_sequencer: RTL and testbench
=======================================

// Module: row_stream_sequencer
// PURPOSE
//  Upstream/downstream companion of the row-by-vector dot-product unit. Walks a dense matrix row by row,
//  streaming each row's NI-wide segments (a) with matching vector segments (p) into the unit.
//  It captures each scalar row result on decoder_read_now into a result memory, forming one full
//  matrix*vector product. Flags completion when all results are written.
// PARAMETERS
//  NI             8   elements per segment (multiplier lanes in the dot-product unit)
//  element_width  32  bits per element (IEEE-754 single)
//  ADDR_W         12  address width of matrix, vector and result memories
//  ROW_W          16  width of row counters / no_of_rows
// PORTS
//  clk               in   1                 rising-edge clock
//  reset             in   1                 synchronous, active-high
//  go                in   1                 1-cycle pulse: start a product (ignored unless IDLE)
//  no_of_rows        in   ROW_W             rows to process; sampled on go
//  no_of_multiples   in   32                segments per row; sampled on go; 0 treated as 1
//  mat_rd_en         out  1                 matrix memory read strobe
//  mat_addr          out  ADDR_W            row*no_of_multiples + seg
//  mat_rd_data       in   NI*element_width  valid cycle after mat_rd_en
//  vec_rd_en         out  1                 vector memory read strobe (same cycle as mat_rd_en)
//  vec_addr          out  ADDR_W            seg
//  vec_rd_data       in   NI*element_width  valid cycle after vec_rd_en
//  a                 out  NI*element_width  row segment to dot-product unit (registered)
//  p                 out  NI*element_width  vector segment to dot-product unit (registered)
//  start_row_by_vector out 1                high with first segment of each row
//  I_am_ready        in   1                 dot-product unit can accept a new row
//  give_me_only      in   1                 pulse: unit consumed all segments of current row
//  decoder_read_now  in   1                 pulse: result valid this cycle
//  result            in   element_width     row result
//  res_wr_en         out  1                 result memory write strobe
//  res_addr          out  ADDR_W            row index of the result being written
//  res_wr_data       out  element_width     registered copy of result
//  busy              out  1                 high from cycle after go until done
//  done              out  1                 1-cycle pulse when last result written
// BEHAVIOUR
//  Reset: all outputs 0, counters 0, slot_free=1, FSM IDLE; reset mid-operation aborts immediately (no done).
//  FSM: IDLE -go-> (rows==0 ? DONE : WAIT_SLOT); WAIT_SLOT -(I_am_ready & slot_free)-> STREAM;
//   STREAM: one read/cycle for seg=0..M-1, M=max(no_of_multiples,1); after last issue ->
//   (rows issued==no_of_rows ? DRAIN : WAIT_SLOT); DRAIN -(results==no_of_rows)-> DONE; DONE -> IDLE (1 cycle).
//  Latency: read issued cycle n -> mem data n+1 -> a/p registered, valid n+2; segments contiguous, no bubbles.
//  start_row_by_vector=1 exactly in the cycle a/p hold segment 0; 0 otherwise. a/p hold last value when idle.
//  slot_free: sticky; cleared on entering STREAM; set by give_me_only. give_me_only while STREAM is kept
//   (row after next may start immediately). A row is never started before the previous row's give_me_only.
//  Results: decoder_read_now -> next cycle res_wr_en=1, res_wr_data=result, res_addr=result counter; counter++.
//   Results are in row order; independent counter, so result capture overlaps streaming of later rows.
//  decoder_read_now in IDLE/DONE ignored (no write). decoder_read_now with give_me_only same cycle: both honoured.
//  Address arithmetic modulo 2^ADDR_W; row*M computed by running base += M (no multiplier).
//  go while busy ignored; done and go same cycle impossible (DONE->IDLE first).
// STRUCTURE
//  Shared package: FSM state encoding (IDLE, WAIT_SLOT, STREAM, DRAIN, DONE), NI/element_width defaults,
//   SEG_W = NI*element_width constant.
//  One natural sub-module: row_result_writer (decoder_read_now -> result memory write + result counter + drain compare).
//  Read-issue/address generation and the 2-stage a/p pipeline stay in the top.
// TESTING
//  T1 rows=2, M=3, I_am_ready=1, give_me_only 2 cycles after seg 2 -> mat_addr 0,1,2 then 3,4,5; two start pulses; res_addr 0,1.
//  T2 rows=4, M=1 -> one-cycle rows, start every row after give_me_only; 4 writes; done after 4th write.
//  T3 rows=0 -> no mat_rd_en, no start; done pulses 2 cycles after go; busy high 1 cycle.
//  T4 I_am_ready low 5 cycles before row 1 -> FSM holds WAIT_SLOT, no reads issued; resumes on cycle I_am_ready=1.
//  T5 reset asserted mid-STREAM of row 1 (rows=3, M=4) -> next cycle all outputs 0, IDLE; new go restarts at addr 0.
//  T6 give_me_only during STREAM + decoder_read_now same cycle -> next row starts without wait; result written correctly.

Source files
------------

// File: rtl/row_stream_sequencer_pkg.sv
// Shared definitions for the row-by-vector stream sequencer: FSM encoding,
// default geometry and a helper for the segments-per-row value.
package row_stream_sequencer_pkg;

    localparam int NI_DEF            = 8;
    localparam int ELEMENT_WIDTH_DEF = 32;
    localparam int SEG_W             = NI_DEF * ELEMENT_WIDTH_DEF;
    localparam int ADDR_W_DEF        = 12;
    localparam int ROW_W_DEF         = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_WAIT_SLOT = 3'd1,
        ST_STREAM    = 3'd2,
        ST_DRAIN     = 3'd3,
        ST_DONE      = 3'd4
    } seq_state_t;

    // A row always has at least one segment.
    function automatic logic [31:0] effective_multiples(input logic [31:0] m);
        return (m == 32'd0) ? 32'd1 : m;
    endfunction

endpackage

// File: rtl/row_stream_sequencer_row_result_writer.sv
// Captures each row result from the dot-product unit into the result memory
// and tells the sequencer when every row of the product has been written.
module row_result_writer #(
    parameter int element_width = 32,
    parameter int ADDR_W        = 12,
    parameter int ROW_W         = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     capture_en,
    input  logic                     decoder_read_now,
    input  logic [element_width-1:0] result,
    input  logic [ROW_W-1:0]         no_of_rows,
    output logic                     res_wr_en,
    output logic [ADDR_W-1:0]        res_addr,
    output logic [element_width-1:0] res_wr_data,
    output logic                     all_written
);

    logic [ROW_W-1:0]         count_r;
    logic                     wr_en_r;
    logic [ADDR_W-1:0]        addr_r;
    logic [element_width-1:0] data_r;
    logic                     accept_s;

    assign accept_s = capture_en & decoder_read_now;

    // Result counter runs independently of the read side so captures overlap streaming.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
            wr_en_r <= 1'b0;
            addr_r  <= '0;
            data_r  <= '0;
        end else begin
            wr_en_r <= accept_s;
            if (clear) begin
                count_r <= '0;
            end else if (accept_s) begin
                count_r <= count_r + {{(ROW_W-1){1'b0}}, 1'b1};
                addr_r  <= ADDR_W'(count_r);
                data_r  <= result;
            end
        end
    end

    assign res_wr_en   = wr_en_r;
    assign res_addr    = addr_r;
    assign res_wr_data = data_r;
    assign all_written = (count_r == no_of_rows);

endmodule

// File: rtl/row_stream_sequencer.sv
// Walks a dense matrix row by row, streaming matrix/vector segments into the
// dot-product unit and collecting the per-row results into the result memory.
module row_stream_sequencer
    import row_stream_sequencer_pkg::*;
#(
    parameter int NI            = NI_DEF,
    parameter int element_width = ELEMENT_WIDTH_DEF,
    parameter int ADDR_W        = ADDR_W_DEF,
    parameter int ROW_W         = ROW_W_DEF
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        go,
    input  logic [ROW_W-1:0]            no_of_rows,
    input  logic [31:0]                 no_of_multiples,
    output logic                        mat_rd_en,
    output logic [ADDR_W-1:0]           mat_addr,
    input  logic [NI*element_width-1:0] mat_rd_data,
    output logic                        vec_rd_en,
    output logic [ADDR_W-1:0]           vec_addr,
    input  logic [NI*element_width-1:0] vec_rd_data,
    output logic [NI*element_width-1:0] a,
    output logic [NI*element_width-1:0] p,
    output logic                        start_row_by_vector,
    input  logic                        I_am_ready,
    input  logic                        give_me_only,
    input  logic                        decoder_read_now,
    input  logic [element_width-1:0]    result,
    output logic                        res_wr_en,
    output logic [ADDR_W-1:0]           res_addr,
    output logic [element_width-1:0]    res_wr_data,
    output logic                        busy,
    output logic                        done
);

    localparam int SEG_LEN = NI * element_width;
    localparam logic [ROW_W-1:0] ROW_ONE = {{(ROW_W-1){1'b0}}, 1'b1};

    seq_state_t          state_r;
    seq_state_t          next_state_s;
    logic [ROW_W-1:0]    rows_r;
    logic [ROW_W-1:0]    rows_issued_r;
    logic [31:0]         mult_r;
    logic [31:0]         seg_r;
    logic [ADDR_W-1:0]   base_r;
    logic                slot_free_r;
    logic                go_accept_s;
    logic                issue_s;
    logic                seg_last_s;
    logic                capture_en_s;
    logic                all_written_s;
    logic                fetch_v_r;
    logic                fetch_first_r;
    logic [SEG_LEN-1:0]  a_r;
    logic [SEG_LEN-1:0]  p_r;
    logic                start_r;
    logic                busy_r;
    logic                done_r;

    assign go_accept_s  = (state_r == ST_IDLE) & go;
    assign issue_s      = (state_r == ST_STREAM);
    assign seg_last_s   = (seg_r == (mult_r - 32'd1));
    assign capture_en_s = (state_r == ST_WAIT_SLOT) | (state_r == ST_STREAM) | (state_r == ST_DRAIN);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (go) begin
                    next_state_s = (no_of_rows == '0) ? ST_DONE : ST_WAIT_SLOT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_WAIT_SLOT: begin
                if (I_am_ready && slot_free_r) begin
                    next_state_s = ST_STREAM;
                end else begin
                    next_state_s = ST_WAIT_SLOT;
                end
            end
            ST_STREAM: begin
                if (seg_last_s) begin
                    next_state_s = ((rows_issued_r + ROW_ONE) == rows_r) ? ST_DRAIN : ST_WAIT_SLOT;
                end else begin
                    next_state_s = ST_STREAM;
                end
            end
            ST_DRAIN: begin
                if (all_written_s) begin
                    next_state_s = ST_DONE;
                end else begin
                    next_state_s = ST_DRAIN;
                end
            end
            ST_DONE: next_state_s = ST_IDLE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    always_comb begin
        mat_rd_en = 1'b0;
        vec_rd_en = 1'b0;
        mat_addr  = '0;
        vec_addr  = '0;
        if (issue_s) begin
            mat_rd_en = 1'b1;
            vec_rd_en = 1'b1;
            mat_addr  = base_r + ADDR_W'(seg_r);
            vec_addr  = ADDR_W'(seg_r);
        end else begin
            mat_rd_en = 1'b0;
            vec_rd_en = 1'b0;
        end
    end

    // Row base advances by M at each row end, so row*M needs no multiplier.
    always_ff @(posedge clk) begin
        if (reset) begin
            rows_r        <= '0;
            rows_issued_r <= '0;
            mult_r        <= '0;
            seg_r         <= '0;
            base_r        <= '0;
            slot_free_r   <= 1'b1;
        end else begin
            if (go_accept_s) begin
                rows_r        <= no_of_rows;
                mult_r        <= effective_multiples(no_of_multiples);
                seg_r         <= '0;
                base_r        <= '0;
                rows_issued_r <= '0;
            end else if (issue_s) begin
                if (seg_last_s) begin
                    seg_r         <= '0;
                    base_r        <= base_r + ADDR_W'(mult_r);
                    rows_issued_r <= rows_issued_r + ROW_ONE;
                end else begin
                    seg_r <= seg_r + 32'd1;
                end
            end
            if ((state_r == ST_WAIT_SLOT) && (next_state_s == ST_STREAM)) begin
                slot_free_r <= 1'b0;
            end else if (give_me_only) begin
                slot_free_r <= 1'b1;
            end
        end
    end

    // Two-stage a/p pipeline: read issue -> memory data -> registered segment.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_v_r     <= 1'b0;
            fetch_first_r <= 1'b0;
            a_r           <= '0;
            p_r           <= '0;
            start_r       <= 1'b0;
        end else begin
            fetch_v_r     <= issue_s;
            fetch_first_r <= issue_s & (seg_r == 32'd0);
            start_r       <= fetch_v_r & fetch_first_r;
            if (fetch_v_r) begin
                a_r <= mat_rd_data;
                p_r <= vec_rd_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (next_state_s != ST_IDLE);
            done_r <= (state_r == ST_DONE);
        end
    end

    row_result_writer #(
        .element_width (element_width),
        .ADDR_W        (ADDR_W),
        .ROW_W         (ROW_W)
    ) u_writer (
        .clk              (clk),
        .reset            (reset),
        .clear            (go_accept_s),
        .capture_en       (capture_en_s),
        .decoder_read_now (decoder_read_now),
        .result           (result),
        .no_of_rows       (rows_r),
        .res_wr_en        (res_wr_en),
        .res_addr         (res_addr),
        .res_wr_data      (res_wr_data),
        .all_written      (all_written_s)
    );

    assign a                   = a_r;
    assign p                   = p_r;
    assign start_row_by_vector = start_r;
    assign busy                = busy_r;
    assign done                = done_r;

endmodule

// File: tb/tb_row_stream_sequencer.sv
// Directed bench for row_stream_sequencer: memories are modelled with data
// derived from the address, and each scenario checks a hand-built timeline.
module tb_row_stream_sequencer;

    localparam int NI = 8;
    localparam int EW = 32;
    localparam int AW = 12;
    localparam int RW = 16;
    localparam int SL = NI * EW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          go = 1'b0;
    logic [RW-1:0] no_of_rows = '0;
    logic [31:0]   no_of_multiples = '0;
    logic          mat_rd_en;
    logic [AW-1:0] mat_addr;
    logic [SL-1:0] mat_rd_data = '0;
    logic          vec_rd_en;
    logic [AW-1:0] vec_addr;
    logic [SL-1:0] vec_rd_data = '0;
    logic [SL-1:0] a;
    logic [SL-1:0] p;
    logic          start_row_by_vector;
    logic          I_am_ready = 1'b1;
    logic          give_me_only = 1'b0;
    logic          decoder_read_now = 1'b0;
    logic [EW-1:0] result = '0;
    logic          res_wr_en;
    logic [AW-1:0] res_addr;
    logic [EW-1:0] res_wr_data;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int t0 = 0;
    int busy_cnt = 0;

    int            rd_cyc[$];
    logic [AW-1:0] rd_mat[$];
    logic [AW-1:0] rd_vec[$];
    int            st_cyc[$];
    logic [SL-1:0] st_a[$];
    logic [SL-1:0] st_p[$];
    int            wr_cyc[$];
    logic [AW-1:0] wr_addr[$];
    logic [EW-1:0] wr_dat[$];
    int            done_cyc[$];

    row_stream_sequencer dut (
        .clk                 (clk),
        .reset               (reset),
        .go                  (go),
        .no_of_rows          (no_of_rows),
        .no_of_multiples     (no_of_multiples),
        .mat_rd_en           (mat_rd_en),
        .mat_addr            (mat_addr),
        .mat_rd_data         (mat_rd_data),
        .vec_rd_en           (vec_rd_en),
        .vec_addr            (vec_addr),
        .vec_rd_data         (vec_rd_data),
        .a                   (a),
        .p                   (p),
        .start_row_by_vector (start_row_by_vector),
        .I_am_ready          (I_am_ready),
        .give_me_only        (give_me_only),
        .decoder_read_now    (decoder_read_now),
        .result              (result),
        .res_wr_en           (res_wr_en),
        .res_addr            (res_addr),
        .res_wr_data         (res_wr_data),
        .busy                (busy),
        .done                (done)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Synchronous memories: lane data encodes the address read.
    always @(posedge clk) begin
        if (mat_rd_en) mat_rd_data <= {NI{{20'hA0000, mat_addr}}};
        if (vec_rd_en) vec_rd_data <= {NI{{20'hB0000, vec_addr}}};
    end

    initial forever begin
        @(negedge clk);
        if (mat_rd_en) begin
            rd_cyc.push_back(cyc - t0);
            rd_mat.push_back(mat_addr);
            rd_vec.push_back(vec_addr);
        end
        if (start_row_by_vector) begin
            st_cyc.push_back(cyc - t0);
            st_a.push_back(a);
            st_p.push_back(p);
        end
        if (res_wr_en) begin
            wr_cyc.push_back(cyc - t0);
            wr_addr.push_back(res_addr);
            wr_dat.push_back(res_wr_data);
        end
        if (done) done_cyc.push_back(cyc - t0);
        if (busy) busy_cnt = busy_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int r);
        while (cyc - t0 < r) tick();
    endtask

    task automatic pulse(input int r, input logic g, input logic d, input logic [EW-1:0] res);
        run_to(r);
        give_me_only = g;
        decoder_read_now = d;
        result = res;
        tick();
        give_me_only = 1'b0;
        decoder_read_now = 1'b0;
    endtask

    task automatic start_product(input logic [RW-1:0] rows, input logic [31:0] m);
        tick();
        rd_cyc.delete(); rd_mat.delete(); rd_vec.delete();
        st_cyc.delete(); st_a.delete(); st_p.delete();
        wr_cyc.delete(); wr_addr.delete(); wr_dat.delete();
        done_cyc.delete();
        busy_cnt = 0;
        t0 = cyc;
        go = 1'b1;
        no_of_rows = rows;
        no_of_multiples = m;
        tick();
        go = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) tick();
        @(negedge clk);
        checks++;
        if (mat_rd_en !== 1'b0 || vec_rd_en !== 1'b0 || mat_addr !== 12'd0 || vec_addr !== 12'd0) begin
            failures++;
            $display("FAIL reset_reads got en=%b/%b addr=%0d/%0d want 0", mat_rd_en, vec_rd_en, mat_addr, vec_addr);
        end
        checks++;
        if (a !== '0 || p !== '0 || start_row_by_vector !== 1'b0) begin
            failures++;
            $display("FAIL reset_ap got a0=%h p0=%h start=%b want 0", a[31:0], p[31:0], start_row_by_vector);
        end
        checks++;
        if (res_wr_en !== 1'b0 || res_addr !== 12'd0 || res_wr_data !== 32'd0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_status got wr=%b addr=%0d data=%h busy=%b done=%b want 0",
                     res_wr_en, res_addr, res_wr_data, busy, done);
        end
        reset = 1'b0;
        tick();
    endtask

    // rows=2, M=3; a second go while busy must be ignored.
    task automatic test_two_rows();
        int e_rc[6] = '{2, 3, 4, 10, 11, 12};
        int e_ra[6] = '{0, 1, 2, 3, 4, 5};
        int e_rv[6] = '{0, 1, 2, 0, 1, 2};
        int e_sc[2] = '{4, 12};
        int e_sa[2] = '{0, 3};
        logic [SL-1:0] seg0_p = {NI{32'hB000_0000}};
        start_product(16'd2, 32'd3);
        run_to(5);
        go = 1'b1;
        no_of_rows = 16'd0;
        tick();
        go = 1'b0;
        pulse(8, 1'b1, 1'b0, 32'd0);
        pulse(9, 1'b0, 1'b1, 32'h1111_1111);
        pulse(16, 1'b1, 1'b0, 32'd0);
        pulse(17, 1'b0, 1'b1, 32'h2222_2222);
        run_to(26);
        checks++;
        if (rd_cyc.size() != 6) begin
            failures++;
            $display("FAIL t1_rd_count got %0d want 6", rd_cyc.size());
        end
        for (int i = 0; i < 6 && i < rd_cyc.size(); i++) begin
            checks++;
            if (rd_cyc[i] !== e_rc[i] || rd_mat[i] !== 12'(e_ra[i]) || rd_vec[i] !== 12'(e_rv[i])) begin
                failures++;
                $display("FAIL t1_rd[%0d] got cyc=%0d mat=%0d vec=%0d want cyc=%0d mat=%0d vec=%0d",
                         i, rd_cyc[i], rd_mat[i], rd_vec[i], e_rc[i], e_ra[i], e_rv[i]);
            end
        end
        checks++;
        if (st_cyc.size() != 2) begin
            failures++;
            $display("FAIL t1_start_count got %0d want 2", st_cyc.size());
        end
        for (int i = 0; i < 2 && i < st_cyc.size(); i++) begin
            checks++;
            if (st_cyc[i] !== e_sc[i] || st_a[i] !== {NI{{20'hA0000, 12'(e_sa[i])}}} || st_p[i] !== seg0_p) begin
                failures++;
                $display("FAIL t1_start[%0d] got cyc=%0d a0=%h p0=%h want cyc=%0d a0=a0000%03h p0=b0000000",
                         i, st_cyc[i], st_a[i][31:0], st_p[i][31:0], e_sc[i], e_sa[i]);
            end
        end
        checks++;
        if (wr_cyc.size() != 2 || wr_cyc[0] !== 10 || wr_addr[0] !== 12'd0 || wr_dat[0] !== 32'h1111_1111
            || wr_cyc[1] !== 18 || wr_addr[1] !== 12'd1 || wr_dat[1] !== 32'h2222_2222) begin
            failures++;
            $display("FAIL t1_writes got n=%0d first=(%0d,%0d,%h) want 2 writes (10,0,11111111) (18,1,22222222)",
                     wr_cyc.size(), wr_cyc[0], wr_addr[0], wr_dat[0]);
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] !== 20) begin
            failures++;
            $display("FAIL t1_done got n=%0d at=%0d want 1 at 20", done_cyc.size(), done_cyc[0]);
        end
        checks++;
        if (busy_cnt !== 19) begin
            failures++;
            $display("FAIL t1_busy got %0d cycles want 19", busy_cnt);
        end
        checks++;
        if (a !== {NI{{20'hA0000, 12'd5}}} || p !== {NI{{20'hB0000, 12'd2}}}) begin
            failures++;
            $display("FAIL t1_hold got a0=%h p0=%h want a0005 b0002", a[31:0], p[31:0]);
        end
    endtask

    // rows=4 with no_of_multiples=0, which behaves as one segment per row.
    task automatic test_single_seg_rows();
        start_product(16'd4, 32'd0);
        for (int k = 0; k < 4; k++) pulse(5 + 5 * k, 1'b1, 1'b1, 32'hC000_0000 + 32'(k));
        run_to(30);
        checks++;
        if (rd_cyc.size() != 4 || st_cyc.size() != 4 || wr_cyc.size() != 4) begin
            failures++;
            $display("FAIL t2_counts got rd=%0d start=%0d wr=%0d want 4/4/4", rd_cyc.size(), st_cyc.size(), wr_cyc.size());
        end
        for (int k = 0; k < 4 && k < rd_cyc.size() && k < st_cyc.size() && k < wr_cyc.size(); k++) begin
            checks++;
            if (rd_cyc[k] !== 2 + 5 * k || rd_mat[k] !== 12'(k) || rd_vec[k] !== 12'd0
                || st_cyc[k] !== 4 + 5 * k || st_a[k][31:0] !== {20'hA0000, 12'(k)}
                || wr_cyc[k] !== 6 + 5 * k || wr_addr[k] !== 12'(k) || wr_dat[k] !== 32'hC000_0000 + 32'(k)) begin
                failures++;
                $display("FAIL t2_row[%0d] got rd=(%0d,%0d,%0d) st=(%0d,%h) wr=(%0d,%0d,%h) want rd=(%0d,%0d,0) st=(%0d) wr=(%0d,%0d)",
                         k, rd_cyc[k], rd_mat[k], rd_vec[k], st_cyc[k], st_a[k][31:0], wr_cyc[k], wr_addr[k], wr_dat[k],
                         2 + 5 * k, k, 4 + 5 * k, 6 + 5 * k, k);
            end
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] !== 23) begin
            failures++;
            $display("FAIL t2_done got n=%0d at=%0d want 1 at 23", done_cyc.size(), done_cyc[0]);
        end
    endtask

    // rows=0: straight to DONE; results offered in DONE/IDLE are not written.
    task automatic test_zero_rows();
        start_product(16'd0, 32'd5);
        pulse(1, 1'b0, 1'b1, 32'hDEAD_0001);
        pulse(4, 1'b0, 1'b1, 32'hDEAD_0002);
        run_to(8);
        checks++;
        if (rd_cyc.size() != 0 || st_cyc.size() != 0 || wr_cyc.size() != 0) begin
            failures++;
            $display("FAIL t3_activity got rd=%0d start=%0d wr=%0d want 0/0/0", rd_cyc.size(), st_cyc.size(), wr_cyc.size());
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] !== 2) begin
            failures++;
            $display("FAIL t3_done got n=%0d at=%0d want 1 at 2", done_cyc.size(), done_cyc[0]);
        end
        checks++;
        if (busy_cnt !== 1) begin
            failures++;
            $display("FAIL t3_busy got %0d cycles want 1", busy_cnt);
        end
    endtask

    // Unit not ready for five cycles before row 1: no reads while stalled.
    task automatic test_ready_stall();
        int e_rc[4] = '{2, 3, 10, 11};
        int e_rv[4] = '{0, 1, 0, 1};
        start_product(16'd2, 32'd2);
        run_to(4);
        I_am_ready = 1'b0;
        pulse(6, 1'b1, 1'b0, 32'd0);
        pulse(7, 1'b0, 1'b1, 32'h4444_0000);
        run_to(9);
        I_am_ready = 1'b1;
        pulse(14, 1'b1, 1'b1, 32'h4444_0001);
        run_to(22);
        checks++;
        if (rd_cyc.size() != 4) begin
            failures++;
            $display("FAIL t4_rd_count got %0d want 4", rd_cyc.size());
        end
        for (int i = 0; i < 4 && i < rd_cyc.size(); i++) begin
            checks++;
            if (rd_cyc[i] !== e_rc[i] || rd_mat[i] !== 12'(i) || rd_vec[i] !== 12'(e_rv[i])) begin
                failures++;
                $display("FAIL t4_rd[%0d] got cyc=%0d mat=%0d vec=%0d want cyc=%0d mat=%0d vec=%0d",
                         i, rd_cyc[i], rd_mat[i], rd_vec[i], e_rc[i], i, e_rv[i]);
            end
        end
        checks++;
        if (st_cyc.size() != 2 || st_cyc[0] !== 4 || st_cyc[1] !== 12) begin
            failures++;
            $display("FAIL t4_start got n=%0d first=%0d want 2 at 4,12", st_cyc.size(), st_cyc[0]);
        end
        checks++;
        if (wr_cyc.size() != 2 || wr_cyc[0] !== 8 || wr_addr[1] !== 12'd1 || wr_dat[1] !== 32'h4444_0001
            || done_cyc.size() != 1 || done_cyc[0] !== 17) begin
            failures++;
            $display("FAIL t4_finish got wr=%0d first_at=%0d done_n=%0d done_at=%0d want 2 8 1 17",
                     wr_cyc.size(), wr_cyc[0], done_cyc.size(), done_cyc[0]);
        end
    endtask

    // Reset in the middle of row 1, then a fresh product from address 0.
    task automatic test_abort();
        start_product(16'd3, 32'd4);
        pulse(10, 1'b1, 1'b1, 32'h5555_0000);
        run_to(13);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (rd_cyc.size() != 6 || rd_cyc[4] !== 12 || rd_mat[5] !== 12'd5 || rd_vec[5] !== 12'd1) begin
            failures++;
            $display("FAIL t5_pre_reset got n=%0d c4=%0d m5=%0d v5=%0d want 6 12 5 1",
                     rd_cyc.size(), rd_cyc[4], rd_mat[5], rd_vec[5]);
        end
        checks++;
        if (mat_rd_en !== 1'b0 || vec_rd_en !== 1'b0 || mat_addr !== 12'd0 || vec_addr !== 12'd0
            || a !== '0 || p !== '0 || start_row_by_vector !== 1'b0) begin
            failures++;
            $display("FAIL t5_reset_read_side got en=%b addr=%0d a0=%h start=%b want 0",
                     mat_rd_en, mat_addr, a[31:0], start_row_by_vector);
        end
        checks++;
        if (res_wr_en !== 1'b0 || res_addr !== 12'd0 || res_wr_data !== 32'd0 || busy !== 1'b0
            || done !== 1'b0 || done_cyc.size() != 0) begin
            failures++;
            $display("FAIL t5_reset_status got wr=%b data=%h busy=%b done=%b dones=%0d want 0",
                     res_wr_en, res_wr_data, busy, done, done_cyc.size());
        end
        start_product(16'd1, 32'd2);
        pulse(6, 1'b1, 1'b1, 32'h6666_0000);
        run_to(14);
        checks++;
        if (rd_cyc.size() != 2 || rd_cyc[0] !== 2 || rd_mat[0] !== 12'd0 || rd_mat[1] !== 12'd1) begin
            failures++;
            $display("FAIL t5_restart_rd got n=%0d c0=%0d m0=%0d want 2 2 0", rd_cyc.size(), rd_cyc[0], rd_mat[0]);
        end
        checks++;
        if (wr_cyc.size() != 1 || wr_cyc[0] !== 7 || wr_addr[0] !== 12'd0 || wr_dat[0] !== 32'h6666_0000
            || done_cyc.size() != 1 || done_cyc[0] !== 9) begin
            failures++;
            $display("FAIL t5_restart_wr got wr=%0d at=%0d addr=%0d data=%h done_at=%0d want 1 7 0 66660000 9",
                     wr_cyc.size(), wr_cyc[0], wr_addr[0], wr_dat[0], done_cyc[0]);
        end
    endtask

    // give_me_only and a result together while row 0 is still streaming.
    task automatic test_early_release();
        int e_rc[8] = '{2, 3, 4, 5, 7, 8, 9, 10};
        start_product(16'd2, 32'd4);
        pulse(3, 1'b1, 1'b1, 32'h7777_0000);
        pulse(13, 1'b1, 1'b1, 32'h8888_0000);
        run_to(22);
        checks++;
        if (rd_cyc.size() != 8) begin
            failures++;
            $display("FAIL t6_rd_count got %0d want 8", rd_cyc.size());
        end
        for (int i = 0; i < 8 && i < rd_cyc.size(); i++) begin
            checks++;
            if (rd_cyc[i] !== e_rc[i] || rd_mat[i] !== 12'(i) || rd_vec[i] !== 12'(i % 4)) begin
                failures++;
                $display("FAIL t6_rd[%0d] got cyc=%0d mat=%0d vec=%0d want cyc=%0d mat=%0d vec=%0d",
                         i, rd_cyc[i], rd_mat[i], rd_vec[i], e_rc[i], i, i % 4);
            end
        end
        checks++;
        if (st_cyc.size() != 2 || st_cyc[0] !== 4 || st_cyc[1] !== 9 || st_a[1][31:0] !== 32'hA000_0004) begin
            failures++;
            $display("FAIL t6_start got n=%0d c0=%0d c1=%0d a0=%h want 2 4 9 a0000004",
                     st_cyc.size(), st_cyc[0], st_cyc[1], st_a[1][31:0]);
        end
        checks++;
        if (wr_cyc.size() != 2 || wr_cyc[0] !== 4 || wr_addr[0] !== 12'd0 || wr_dat[0] !== 32'h7777_0000
            || wr_cyc[1] !== 14 || wr_addr[1] !== 12'd1 || wr_dat[1] !== 32'h8888_0000) begin
            failures++;
            $display("FAIL t6_writes got n=%0d first=(%0d,%0d,%h) want (4,0,77770000) (14,1,88880000)",
                     wr_cyc.size(), wr_cyc[0], wr_addr[0], wr_dat[0]);
        end
        checks++;
        if (done_cyc.size() != 1 || done_cyc[0] !== 16) begin
            failures++;
            $display("FAIL t6_done got n=%0d at=%0d want 1 at 16", done_cyc.size(), done_cyc[0]);
        end
    endtask

    initial begin
        test_reset();
        test_two_rows();
        test_single_seg_rows();
        test_zero_rows();
        test_ready_stall();
        test_abort();
        test_early_release();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
